// File: rtl/capture_sequencer.sv
// capture_sequencer: arms the ADC trigger, counts bursts/words from a passive AXI-Stream tap.
// Define CAPSEQ_TIMEOUT_EN to enable the ARMED-state timeout (timed_out flag, timeout counter).
module capture_sequencer #(
  parameter int CLR_CYCLES = 4,
  parameter int CNT_W      = 32
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             start,
  input  logic             abort,
  input  logic [15:0]      burst_target,
  input  logic [CNT_W-1:0] holdoff,
  input  logic [CNT_W-1:0] timeout,
  input  logic             trig_activated,
  input  logic             s_tvalid,
  input  logic             s_tlast,
  output logic             nreset_trigger,
  output logic             nreset_max_sum,
  output logic             busy,
  output logic             done,
  output logic             timed_out,
  output logic             aborted,
  output logic [15:0]      bursts_done,
  output logic [CNT_W-1:0] words_done,
  output logic [2:0]       state
);
  typedef enum logic [2:0] {
    IDLE = 3'd0, CLEAR = 3'd1, ARMED = 3'd2, CAPTURE = 3'd3, HOLDOFF = 3'd4, DONE = 3'd5
  } state_t;
  localparam logic [7:0] CLR_LAST = 8'(CLR_CYCLES - 1);
  state_t state_q, state_d, end_st;
  logic [7:0] clr_cnt_q, clr_cnt_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d, words_q, words_d;
  logic [15:0] bursts_q, bursts_d, bursts_inc;
  logic first_q, first_d, aborted_q, aborted_d, timed_out_q, timed_out_d;
  logic busy_q, busy_d, done_q, done_d, ntrig_q, ntrig_d, nmax_q, nmax_d;
  logic word, eob, to_hit;
  assign word       = (state_q == ARMED || state_q == CAPTURE) && s_tvalid;
  assign eob        = word && s_tlast;
  assign bursts_inc = &bursts_q ? bursts_q : bursts_q + 16'd1;
  assign end_st     = (burst_target != 16'd0 && bursts_inc == burst_target) ? DONE :
                      (holdoff == '0 ? CLEAR : HOLDOFF);
`ifdef CAPSEQ_TIMEOUT_EN
  logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
  assign to_cnt_d = state_q == ARMED ? to_cnt_q + CNT_W'(1) : '0;
  assign to_hit   = timeout != '0 && to_cnt_q + CNT_W'(1) == timeout;
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) to_cnt_q <= '0;
    else          to_cnt_q <= to_cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^timeout;
  assign to_hit = 1'b0;
`endif
  always_comb begin
    state_d     = state_q;
    first_d     = first_q;
    aborted_d   = aborted_q;
    timed_out_d = timed_out_q;
    bursts_d    = eob ? bursts_inc : bursts_q;
    words_d     = word && !(&words_q) ? words_q + CNT_W'(1) : words_q;
    case (state_q)
      IDLE: if (start && !abort) begin
        state_d     = CLEAR;
        first_d     = 1'b1;
        aborted_d   = 1'b0;
        timed_out_d = 1'b0;
        bursts_d    = '0;
        words_d     = '0;
      end
      CLEAR: if (clr_cnt_q == CLR_LAST) begin
        state_d = aborted_q ? IDLE : ARMED;
        first_d = 1'b0;
      end
      ARMED: if (eob) state_d = end_st;
        else if (trig_activated || s_tvalid) state_d = CAPTURE;
        else if (to_hit) begin
          state_d     = DONE;
          timed_out_d = 1'b1;
        end
      CAPTURE: if (eob) state_d = end_st;
      HOLDOFF: if (hold_cnt_q == holdoff - CNT_W'(1)) state_d = CLEAR;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Abort overrides every other transition and restarts the clear window.
    if (abort && state_q != IDLE) begin
      state_d     = CLEAR;
      aborted_d   = 1'b1;
      first_d     = first_q;
      timed_out_d = timed_out_q;
    end
  end
  assign clr_cnt_d  = (state_q == CLEAR && !abort) ? clr_cnt_q + 8'd1 : 8'd0;
  assign hold_cnt_d = state_q == HOLDOFF ? hold_cnt_q + CNT_W'(1) : '0;
  assign busy_d     = state_d != IDLE;
  assign done_d     = state_d == DONE;
  assign ntrig_d    = state_d == ARMED || state_d == CAPTURE;
  assign nmax_d     = !(state_d == CLEAR && first_d);
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      state_q     <= IDLE;
      clr_cnt_q   <= '0;
      hold_cnt_q  <= '0;
      bursts_q    <= '0;
      words_q     <= '0;
      first_q     <= 1'b0;
      aborted_q   <= 1'b0;
      timed_out_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ntrig_q     <= 1'b0;
      nmax_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      bursts_q    <= bursts_d;
      words_q     <= words_d;
      first_q     <= first_d;
      aborted_q   <= aborted_d;
      timed_out_q <= timed_out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ntrig_q     <= ntrig_d;
      nmax_q      <= nmax_d;
    end
  assign state          = state_q;
  assign nreset_trigger = ntrig_q;
  assign nreset_max_sum = nmax_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign timed_out      = timed_out_q;
  assign aborted        = aborted_q;
  assign bursts_done    = bursts_q;
  assign words_done     = words_q;
endmodule

// File: doc/capture_sequencer.md
CAPTURE_SEQUENCER -- requirements
Module: capture_sequencer

Interface
REQ-001 SHALL have parameter CLR_CYCLES, default 4, meaning the cycles nreset_trigger is held low in CLEAR before each arm (range 1..255).
REQ-002 SHALL have parameter CNT_W, default 32, meaning the width of the holdoff, timeout and words_done counters.
REQ-003 SHALL have port aclk, input, 1, the system clock; all logic is rising-edge.
REQ-004 SHALL have port aresetn, input, 1; reset is aresetn, asynchronous, active-low; clock is aclk.
REQ-005 SHALL have port start, input, 1, a single-cycle request to begin a capture sequence.
REQ-006 SHALL have port abort, input, 1, a single-cycle request to stop the sequence.
REQ-007 SHALL have port burst_target, input, 16, the number of bursts to capture; 0 means continuous.
REQ-008 SHALL have port holdoff, input, CNT_W, the idle cycles between the end of a burst and the next CLEAR.
REQ-009 SHALL have port timeout, input, CNT_W, the maximum cycles in ARMED; 0 disables the timeout.
REQ-010 SHALL have port trig_activated, input, 1, the trigger-active flag from the ADC trigger block.
REQ-011 SHALL have ports s_tvalid and s_tlast, input, 1 each, a passive tap of the ADC AXI-Stream.
REQ-012 SHALL have port nreset_trigger, output, 1, the trigger clear to the ADC block, active-low.
REQ-013 SHALL have port nreset_max_sum, output, 1, the maximum-sum clear to the ADC block, active-low.
REQ-014 SHALL have ports busy, done, timed_out and aborted, output, 1 each, the status flags.
REQ-015 SHALL have port bursts_done, output, 16, and port words_done, output, CNT_W, the progress counters.
REQ-016 SHALL have port state, output, 3, the state encoding: IDLE=0, CLEAR=1, ARMED=2, CAPTURE=3, HOLDOFF=4, DONE=5.

Function
REQ-017 SHALL drive nreset_trigger=1 only in ARMED and CAPTURE, and 0 in every other state.
REQ-018 SHALL drive nreset_max_sum=0 only during the first CLEAR after start, and 1 otherwise.
REQ-019 SHALL, in IDLE, when start=1 and abort=0, clear bursts_done, words_done, timed_out and aborted, then enter CLEAR on the next cycle.
REQ-020 SHALL ignore start whenever the state is not IDLE.
REQ-021 SHALL, in CLEAR, remain exactly CLR_CYCLES cycles, then enter ARMED.
REQ-022 SHALL, in ARMED, enter CAPTURE on trig_activated=1 or s_tvalid=1.
REQ-023 SHALL increment words_done on every cycle with s_tvalid=1 in ARMED or CAPTURE, saturating at all-ones.
REQ-024 SHALL treat s_tvalid=1 with s_tlast=1 in ARMED or CAPTURE as the end of a burst, counting that word, and increment bursts_done, saturating at 0xFFFF.
REQ-025 SHALL, on a burst end, enter DONE if burst_target!=0 and the incremented bursts_done equals burst_target.
REQ-026 SHALL, on a burst end that does not reach burst_target, enter HOLDOFF, or enter CLEAR directly if holdoff=0.
REQ-027 SHALL, in HOLDOFF, count holdoff cycles, then enter CLEAR.
REQ-028 SHALL, in DONE, pulse done=1 for exactly one cycle, then return to IDLE.
REQ-029 SHALL, on abort=1 in any non-IDLE state, set aborted=1 and enter CLEAR.
REQ-030 SHALL, after an abort, leave CLEAR for IDLE instead of ARMED, and SHALL NOT assert done.
REQ-031 SHALL give abort priority over start, burst end and timeout in the same cycle.
REQ-032 SHALL drive busy=1 in every state except IDLE.
REQ-033 SHALL register all outputs; state changes are visible 1 cycle after the causing input.

Reset
REQ-034 SHALL, while aresetn=0, set state=IDLE, nreset_trigger=0, nreset_max_sum=1, busy=0, done=0, timed_out=0, aborted=0, bursts_done=0, words_done=0, and clear all internal counters.
REQ-035 SHALL, on aresetn deassertion mid-sequence, resume in IDLE with no done pulse.

Configuration
REQ-036 SHALL, with CAPSEQ_TIMEOUT_EN defined, count cycles in ARMED and, when the count reaches a nonzero timeout, set timed_out=1 (sticky until the next start) and enter DONE.
REQ-037 SHALL, without CAPSEQ_TIMEOUT_EN, tie timed_out to 0, ignore the timeout port, and contain no timeout counter.

Verification
REQ-038 SHALL cover: burst_target=2, holdoff=10, two 8-word bursts with tlast -> bursts_done=2, words_done=16, one done pulse, nreset_trigger low for exactly 10+4 cycles between the bursts.
REQ-039 SHALL cover: start -> nreset_max_sum low 4 cycles only in the first CLEAR; the second CLEAR keeps it high.
REQ-040 SHALL cover: abort during CAPTURE after 5 words -> aborted=1, 4-cycle CLEAR, then IDLE, done never asserted, words_done=5.
REQ-041 SHALL cover: start and abort in the same cycle in IDLE -> state stays IDLE and busy stays 0.
REQ-042 SHALL cover: CAPSEQ_TIMEOUT_EN defined, timeout=100, no trigger -> timed_out=1 and done pulse 100 cycles after ARMED entry; with the macro undefined, the sequencer remains in ARMED.
REQ-043 SHALL cover: tvalid and tlast in the first ARMED cycle with burst_target=1 -> words_done=1, bursts_done=1, DONE.
